alu_issue_ctrl: RTL and testbench

Sequencer directly upstream of the 8-bit ALU (ports a, b, op, c_in in; out, c_out, zero out). It accepts a command over a valid/ready handshake and reads two operands from a 4-entry x 8-bit register file. It drives registered operands to the ALU, captures the ALU result and flags, writes the result back to the register file and pulses done. A load port preloads the register file.

---
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command sequencer that sits directly in front of an 8-bit
// combinational ALU.
//
// A command is accepted over a valid/ready handshake. The block then:
//   - reads two operands from a small register file,
//   - drives registered operands to the ALU,
//   - captures the ALU result and flags,
//   - writes the result back to the register file,
//   - pulses done.
// A separate load port can write the register file in any state.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_op, cmd_use_c              ALU opcode; carry-in source select
//   cmd_rd, cmd_rs, cmd_rt         destination / source-a / source-b registers
//   ld_en, ld_addr, ld_data        register-file load port
//   alu_a/alu_b/alu_op/alu_cin     registered ALU operands
//   alu_out/alu_c_out/alu_zero     ALU result and flags
//   res_data/res_c/res_zero        last captured result; res_c is also the stored carry
//   done                           one-cycle completion pulse
//   dbg_addr/dbg_data              combinational register-file read
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cmd_ready high; a handshake latches the command
// OPER  | operands read from the register file into alu_* registers
// EXEC  | ALU inputs stable; result, flags and writeback captured at the end edge
// DONE  | completion; done is registered out of this state, so it shows
//       | in the following cycle, which is also the next IDLE
module alu_issue_ctrl #(
    parameter int DW   = 8,
    parameter int NREG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic                    cmd_use_c,
    input  logic [$clog2(NREG)-1:0] cmd_rd,
    input  logic [$clog2(NREG)-1:0] cmd_rs,
    input  logic [$clog2(NREG)-1:0] cmd_rt,
    input  logic                    ld_en,
    input  logic [$clog2(NREG)-1:0] ld_addr,
    input  logic [DW-1:0]           ld_data,
    output logic [DW-1:0]           alu_a,
    output logic [DW-1:0]           alu_b,
    output logic [2:0]              alu_op,
    output logic                    alu_cin,
    input  logic [DW-1:0]           alu_out,
    input  logic                    alu_c_out,
    input  logic                    alu_zero,
    output logic [DW-1:0]           res_data,
    output logic                    res_c,
    output logic                    res_zero,
    output logic                    done,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DW-1:0]           dbg_data
);

    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPER = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] regs [NREG];
    logic [2:0]    op_q;
    logic          use_c_q;
    logic [AW-1:0] rd_q, rs_q, rt_q;
    logic          accept;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign dbg_data  = regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_OPER;
            S_OPER: state_nxt = S_EXEC;
            S_EXEC: state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            use_c_q <= 1'b0;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
        end else if (accept) begin
            op_q    <= cmd_op;
            use_c_q <= cmd_use_c;
            rd_q    <= cmd_rd;
            rs_q    <= cmd_rs;
            rt_q    <= cmd_rt;
        end
    end

    // The alu_* registers load only in OPER, so the ALU sees stable inputs
    // between commands. The carry is taken from res_c, which is read here
    // before the EXEC of this command can update it.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            alu_cin <= 1'b0;
        end else if (state == S_OPER) begin
            alu_a   <= regs[rs_q];
            alu_b   <= regs[rt_q];
            alu_op  <= op_q;
            alu_cin <= use_c_q ? res_c : op_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_data <= '0;
            res_c    <= 1'b0;
            res_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_EXEC) begin
                res_data <= alu_out;
                res_c    <= alu_c_out;
                res_zero <= alu_zero;
            end
        end
    end

    // The writeback is the later assignment, so it overrides a load to the
    // same address in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (ld_en)            regs[ld_addr] <= ld_data;
            if (state == S_EXEC)  regs[rd_q]    <= alu_out;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_use_c;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd, cmd_rs, cmd_rt;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_a, alu_b, alu_out, res_data, dbg_data;
    logic [2:0] alu_op;
    logic       alu_cin, alu_c_out, alu_zero, res_c, res_zero, done;
    logic [1:0] dbg_addr;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_use_c(cmd_use_c), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_c_out(alu_c_out), .alu_zero(alu_zero),
        .res_data(res_data), .res_c(res_c), .res_zero(res_zero), .done(done),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] a, b;
        logic [2:0] op;
        logic       cin;
        logic [7:0] res;
        logic       c, z;
        int         hs;
    } exp_t;

    exp_t exp_q[$];
    int nvec   = 0;
    int nerr   = 0;
    int n_done = 0;
    int last_hs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_done: got done=1, expected no pending command (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("alu_a",    alu_a,    e.a);
                chk("alu_b",    alu_b,    e.b);
                chk("alu_op",   alu_op,   e.op);
                chk("alu_cin",  alu_cin,  e.cin);
                chk("res_data", res_data, e.res);
                chk("res_c",    res_c,    e.c);
                chk("res_zero", res_zero, e.z);
                chk("latency",  cyc - e.hs, 4);
                n_done++;
            end
        end
    end

    task automatic stub(input logic [7:0] o, input logic c, input logic z);
        alu_out = o; alu_c_out = c; alu_zero = z;
    endtask

    // Offers a command and returns just after the accepting edge; cmd_valid is
    // left high. The expectation carries hand-computed operands and the
    // current stub result.
    task automatic send(input logic [2:0] op, input logic use_c, input logic [1:0] rd,
                        input logic [1:0] rs, input logic [1:0] rt,
                        input logic [7:0] ea, input logic [7:0] eb, input logic ecin,
                        input bit push);
        exp_t e;
        int t = 0;
        @(negedge clk);
        cmd_op = op; cmd_use_c = use_c; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 0, 1);
            return;
        end
        e.a = ea; e.b = eb; e.op = op; e.cin = ecin;
        e.res = alu_out; e.c = alu_c_out; e.z = alu_zero; e.hs = cyc;
        last_hs = cyc;
        if (push) exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic load(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic rd_reg(input string name, input logic [1:0] addr, input logic [7:0] expv);
        dbg_addr = addr;
        #1;
        chk(name, dbg_data, expv);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_alu_a"},     alu_a,     0);
        chk({tag, "_alu_b"},     alu_b,     0);
        chk({tag, "_alu_op"},    alu_op,    0);
        chk({tag, "_alu_cin"},   alu_cin,   0);
        chk({tag, "_res_data"},  res_data,  0);
        chk({tag, "_res_c"},     res_c,     0);
        chk({tag, "_res_zero"},  res_zero,  0);
        for (int i = 0; i < 4; i++) rd_reg({tag, "_reg"}, 2'(i), 8'h00);
    endtask

    int hs_burst [3];
    int done_before;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_use_c = 1'b0;
        cmd_rd = '0; cmd_rs = '0; cmd_rt = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        stub(8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_cleared("reset");

        // Basic add: R2 = R0 + R1 -> 95 + 14 = 109
        load(2'd0, 8'd95);
        load(2'd1, 8'd14);
        stub(8'd109, 1'b0, 1'b0);
        send(3'b000, 1'b0, 2'd2, 2'd0, 2'd1, 8'd95, 8'd14, 1'b0, 1);
        @(negedge clk) cmd_valid = 1'b0;
        wait_idle();
        rd_reg("wb_r2", 2'd2, 8'd109);

        // op[0] drives carry-in; stub sets carry and zero flags
        stub(8'h00, 1'b1, 1'b1);
        send(3'b001, 1'b0, 2'd3, 2'd2, 2'd0, 8'd109, 8'd95, 1'b1, 1);
        @(negedge clk) cmd_valid = 1'b0;
        wait_idle();
        rd_reg("wb_r3", 2'd3, 8'h00);

        // use_c takes the stored carry (1) even though op[0] = 0
        stub(8'h42, 1'b0, 1'b0);
        send(3'b000, 1'b1, 2'd0, 2'd1, 2'd3, 8'd14, 8'h00, 1'b1, 1);
        @(negedge clk) cmd_valid = 1'b0;
        wait_idle();
        rd_reg("wb_r0", 2'd0, 8'h42);

        // Burst with cmd_valid held high: R0=42 R1=0E R2=6D R3=00
        done_before = n_done;
        stub(8'h11, 1'b1, 1'b0);
        send(3'b010, 1'b0, 2'd1, 2'd0, 2'd2, 8'h42, 8'd109, 1'b0, 1);
        hs_burst[0] = last_hs;
        send(3'b011, 1'b1, 2'd2, 2'd1, 2'd1, 8'h11, 8'h11, 1'b1, 1);
        hs_burst[1] = last_hs;
        send(3'b100, 1'b0, 2'd3, 2'd2, 2'd0, 8'h11, 8'h42, 1'b0, 1);
        hs_burst[2] = last_hs;
        @(negedge clk) cmd_valid = 1'b0;
        wait_idle();
        chk("burst_gap0", hs_burst[1] - hs_burst[0], 4);
        chk("burst_gap1", hs_burst[2] - hs_burst[1], 4);
        chk("burst_dones", n_done - done_before, 3);

        // Load to R2 in the EXEC cycle of a writeback to R2: writeback wins
        stub(8'h5A, 1'b0, 1'b0);
        send(3'b101, 1'b0, 2'd2, 2'd0, 2'd1, 8'h42, 8'h11, 1'b1, 1);
        @(negedge clk) cmd_valid = 1'b0;
        @(negedge clk) begin ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'hAA; end
        @(negedge clk) ld_en = 1'b0;
        wait_idle();
        rd_reg("collide_r2", 2'd2, 8'h5A);

        // Load to R3 in the EXEC cycle of a writeback to R2 (rd = rs): both land
        stub(8'h77, 1'b0, 1'b0);
        send(3'b110, 1'b0, 2'd2, 2'd2, 2'd3, 8'h5A, 8'h11, 1'b0, 1);
        @(negedge clk) cmd_valid = 1'b0;
        @(negedge clk) begin ld_en = 1'b1; ld_addr = 2'd3; ld_data = 8'hCC; end
        @(negedge clk) ld_en = 1'b0;
        wait_idle();
        rd_reg("both_r2", 2'd2, 8'h77);
        rd_reg("both_r3", 2'd3, 8'hCC);

        // Reset during EXEC: no done, everything cleared
        done_before = n_done;
        stub(8'h99, 1'b1, 1'b0);
        send(3'b000, 1'b0, 2'd1, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 0);
        @(negedge clk) cmd_valid = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_cleared("rst_exec");
        repeat (6) @(negedge clk);
        chk("rst_exec_no_done", n_done - done_before, 0);
        rd_reg("rst_exec_rd", 2'd1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
